// File: rtl/stream_rr_arbiter.sv
// Packet-aware round-robin arbiter: merges NREQ valid/ready streams onto one
// registered output stream, holding the grant until the end-of-packet beat.
module stream_rr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          s_valid,
    output logic [NREQ-1:0]          s_ready,
    input  logic [NREQ*DWIDTH-1:0]   s_data,
    input  logic [NREQ-1:0]          s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DWIDTH-1:0]        m_data,
    output logic                     m_last,
    output logic [IDW-1:0]           m_id,
    output logic                     busy
);

    // Handshake: a beat moves on any interface when valid and ready are both
    // high at a rising edge; s_ready is combinational and one-hot or zero.

    typedef enum logic {IDLE, LOCK} state_t;

    state_t            state, state_next;
    logic [IDW-1:0]    ptr, ptr_next, gnt, gnt_next;
    logic [IDW-1:0]    winner, sel;
    logic              found, load_en, take;
    logic [DWIDTH-1:0] s_beat [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign s_beat[g] = s_data[g*DWIDTH +: DWIDTH];
    end

    // Rotating search starting one past the last packet's owner.
    always_comb begin : pick
        logic [IDW-1:0] cand;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NREQ);
            if (!found && s_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin : fsm_next
        load_en    = ~m_valid | m_ready;
        sel        = (state == LOCK) ? gnt : winner;
        s_ready    = '0;
        state_next = state;
        ptr_next   = ptr;
        gnt_next   = gnt;
        if (rst_n && load_en && (state == LOCK || found)) begin
            s_ready[sel] = 1'b1;
        end
        take = |(s_valid & s_ready);
        if (take) begin
            case (state)
                IDLE: begin
                    if (s_last[sel]) begin
                        ptr_next = sel;
                    end else begin
                        state_next = LOCK;
                        gnt_next   = sel;
                    end
                end
                LOCK: begin
                    if (s_last[sel]) begin
                        state_next = IDLE;
                        ptr_next   = sel;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin : fsm_reg
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= IDW'(NREQ - 1);
            gnt   <= '0;
        end else begin
            state <= state_next;
            ptr   <= ptr_next;
            gnt   <= gnt_next;
        end
    end

    // Output register: reloads whenever it is empty or being drained.
    always_ff @(posedge clk) begin : out_reg
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_id    <= '0;
        end else if (load_en) begin
            m_valid <= take;
            if (take) begin
                m_data <= s_beat[sel];
                m_last <= s_last[sel];
                m_id   <= sel;
            end
        end
    end

    assign busy = (state == LOCK);

endmodule
